// File: rtl/alu_pkg.sv
// Shared definitions for the registered add/subtract ALU: default width,
// operation encoding and the status-flag bundle.
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sum = a + (b ^ {sub}) + sub, with carry-out
// (NOT borrow when subtracting) and two's-complement overflow.
module alu_addsub #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   full;

  assign b_eff = b ^ {DATA_W{sub}};
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  assign sum   = full[DATA_W-1:0];
  assign cout  = full[DATA_W];
  // Overflow seen on the effective addend covers both ADD and SUB cases.
  assign ovf   = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule : alu_addsub

// File: rtl/alu_unit.sv
// Registered two-operand ADD/SUB ALU with one cycle of latency and a valid
// qualifier. Define ALU_FLAGS_EN to add registered z/n/c/v status flags.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              select,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v
`endif
);

  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              ovf;
  logic              sub;

  assign sub = (select == OP_SUB);

  alu_addsub #(.DATA_W(DATA_W)) u_addsub (
    .a    (rd_data),
    .b    (rs_data),
    .sub  (sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= sum;
    end
  end

`ifdef ALU_FLAGS_EN
  flags_t flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (in_valid) begin
      flags.z <= (sum == '0);
      flags.n <= sum[DATA_W-1];
      flags.c <= cout;
      flags.v <= ovf;
    end
  end

  assign flag_z = flags.z;
  assign flag_n = flags.n;
  assign flag_c = flags.c;
  assign flag_v = flags.v;
`else
  logic unused_status;
  assign unused_status = &{1'b0, cout, ovf};
`endif

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, async reset
// sequences, streaming/hold sequence and randomized traffic against a model.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] rd_data = '0;
  logic [7:0] rs_data = '0;
  logic       select = 1'b0;
  logic [7:0] out;
  logic       out_valid;
`ifdef ALU_FLAGS_EN
  logic       flag_z, flag_n, flag_c, flag_v;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_unit #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rd_data   (rd_data),
    .rs_data   (rs_data),
    .select    (select),
    .out       (out),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
`endif
  );

  // Reference model state
  int exp_out   = 0;
  int exp_valid = 0;
`ifdef ALU_FLAGS_EN
  int exp_f     = 0;  // {z,n,c,v}
`endif

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] eo;
    logic       ev;
    logic [3:0] ef;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_out   = 0;
    exp_valid = 0;
`ifdef ALU_FLAGS_EN
    exp_f     = 0;
`endif
  endtask

  task automatic model_apply(input logic v, input int a, input int b, input logic s);
    int r, sa, sb, sr;
    exp_valid = v ? 1 : 0;
    if (v) begin
      r  = s ? (a - b + 256) % 256 : (a + b) % 256;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      sr = s ? sa - sb : sa + sb;
      exp_out = r;
`ifdef ALU_FLAGS_EN
      exp_f = ((r == 0) ? 8 : 0) + ((r >= 128) ? 4 : 0)
            + ((s ? (a >= b) : (a + b > 255)) ? 2 : 0)
            + ((sr > 127 || sr < -128) ? 1 : 0);
`endif
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    in_valid = v; rd_data = a; rs_data = b; select = s;
    @(posedge clk);
    model_apply(v, int'(a), int'(b), s);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"}, int'(out), exp_out);
    chk({tag, ".valid"}, int'(out_valid), exp_valid);
`ifdef ALU_FLAGS_EN
    chk({tag, ".flags"}, int'({flag_z, flag_n, flag_c, flag_v}), exp_f);
`endif
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b1, 4'b0000};
    tbl[1] = '{1'b1, 8'h03, 8'h02, 1'b1, 8'h01, 1'b1, 4'b0010};
    tbl[2] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'b1010};
    tbl[3] = '{1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 4'b0100};
    tbl[4] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 4'b0101};
    tbl[5] = '{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 4'b0011};
    tbl[6] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h7F, 1'b0, 4'b0011};
    tbl[7] = '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 4'b1011};
    tbl[8] = '{1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 4'b1010};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("reset_async_initial");
    @(negedge clk); rst = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check_model("reset_release_idle");

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].s);
      chk($sformatf("vec%0d.out", i), int'(out), int'(tbl[i].eo));
      chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(tbl[i].ev));
`ifdef ALU_FLAGS_EN
      chk($sformatf("vec%0d.flags", i), int'({flag_z, flag_n, flag_c, flag_v}), int'(tbl[i].ef));
`endif
    end

    // Reset asserted mid-cycle after a valid result: must clear before next edge
    step(1'b1, 8'h21, 8'h13, 1'b0);
    check_model("pre_reset");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_model("reset_async_midstream");
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_model("reset_release_hold0");
    @(posedge clk); #1;
    check_model("reset_release_hold1");

    // Release with operands already present: first edge samples them
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; rd_data = 8'h40; rs_data = 8'h0C; select = 1'b1;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    @(posedge clk);
    model_apply(1'b1, 32'h40, 32'h0C, 1'b1);
    #1;
    check_model("release_no_warmup");

    // Streaming with alternating select, then hold
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'(i % 2));
      check_model($sformatf("stream%0d", i));
    end
    step(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    check_model("stream_drop");
    step(1'b0, 8'($urandom), 8'($urandom), 1'b1);
    check_model("stream_hold");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_unit
